// File: rtl/fifo_write_arbiter_if.sv
// Purpose: bundles the producer handshake and FIFO write-port signals shared
//          between fifo_write_arbiter and its environment.
// Signals (directions given from the arbiter's point of view):
//   req_valid_i    [NREQ]       per-requester beat valid
//   req_data_i     [NREQ*DW]    requester k payload at [k*DW +: DW]
//   req_last_i     [NREQ]       final beat of the requester's packet
//   req_ready_o    [NREQ]       beat accepted this cycle
//   fifo_wr_en_o   [1]          FIFO write strobe
//   fifo_wr_data_o [IDW+DW]     {grant index, payload}
//   fifo_full_i    [1]          FIFO full flag
//   grant_o        [NREQ]       one-hot current grant, 0 when idle
//   busy_o         [1]          high while a burst is granted
// Modports: master = arbiter side, slave = producers/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_last_i;
  logic [NREQ-1:0]    req_ready_o;
  logic               fifo_wr_en_o;
  logic [IDW+DW-1:0]  fifo_wr_data_o;
  logic               fifo_full_i;
  logic [NREQ-1:0]    grant_o;
  logic               busy_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
    output req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, fifo_full_i,
    input  req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Purpose: round-robin arbiter sharing one FIFO write port between NREQ
//          producers. One requester is granted per burst; each written beat is
//          tagged with the requester index. Never writes while the FIFO is full.
// Ports:
//   clk_i    write-side clock (FIFO wr_clk_i)
//   rst_n_i  synchronous active-low reset
//   bus      fifo_write_arbiter_if.master (handshake, FIFO write, grant, busy)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; scan valids from rr_ptr and load the winner
// BURST | gidx owns the write port until last, MAX_BURST beats, or valid drop
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  fifo_write_arbiter_if.master  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q,    state_d;
  logic [IDW-1:0]  gidx_q,     gidx_d;
  logic [IDW-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0] grant_q,    grant_d;

  logic            busy;
  logic            cur_valid;
  logic            cur_last;
  logic [DW-1:0]   cur_data;
  logic            wr_en;
  logic [CW-1:0]   cnt_inc;
  logic            rel_burst;
  logic            found;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  scan_idx;

  assign busy      = (state_q == BURST);
  assign cur_valid = bus.req_valid_i[gidx_q];
  assign cur_last  = bus.req_last_i[gidx_q];
  assign cur_data  = bus.req_data_i[int'(gidx_q)*DW +: DW];
  assign cnt_inc   = beat_cnt_q + CW'(1);

  // Strobes are gated by reset so that the reset edge itself never commits
  // a beat of the abandoned burst.
  assign wr_en = busy & rst_n_i & cur_valid & ~bus.fifo_full_i;

  always_comb begin
    bus.req_ready_o = '0;
    if (busy && rst_n_i) bus.req_ready_o[gidx_q] = ~bus.fifo_full_i;
  end

  assign bus.fifo_wr_en_o   = wr_en;
  assign bus.fifo_wr_data_o = busy ? {gidx_q, cur_data} : '0;
  assign bus.grant_o        = grant_q;
  assign bus.busy_o         = busy;

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    found      = 1'b0;
    sel        = '0;
    scan_idx   = '0;
    rel_burst  = 1'b0;

    // First valid requester at or after rr_ptr, wrapping mod NREQ.
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && bus.req_valid_i[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          gidx_d     = sel;
          beat_cnt_d = '0;
          grant_d    = NREQ'(1) << sel;
        end
      end
      BURST: begin
        if (wr_en) begin
          beat_cnt_d = cnt_inc;
          rel_burst  = cur_last || (cnt_inc == CW'(MAX_BURST));
        end else if (!cur_valid) begin
          rel_burst  = 1'b1;
        end
        if (rel_burst) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = IDW'((int'(gidx_q) + 1) % NREQ);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end
endmodule
